// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared direction constants and op-code type for the up/down counter
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_INC  = 2'd2,
        OP_DEC  = 2'd3
    } op_e;

endpackage

// File: rtl/updown_counter_param_if.sv
// rtl/updown_counter_param_if.sv - counter control/status bundle; ovf present only with COUNTER_SAT_EN
interface updown_counter_param_if #(
    parameter int WIDTH = 3
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] Q;
    logic             tc;
`ifdef COUNTER_SAT_EN
    logic             ovf;

    modport master (output en, up, load, load_val, input Q, tc, ovf);
    modport slave  (input en, up, load, load_val, output Q, tc, ovf);
`else
    modport master (output en, up, load, load_val, input Q, tc);
    modport slave  (input en, up, load, load_val, output Q, tc);
`endif
endinterface

// File: rtl/counter_step.sv
// rtl/counter_step.sv - combinational next-count, boundary and load clamp; COUNTER_SAT_EN selects saturation
module counter_step
    import counter_pkg::*;
#(
    parameter int              WIDTH   = 3,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic [WIDTH-1:0] q_i,
    input  op_e              op_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] q_o,
    output logic             boundary_o
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH:0]   ONE_W = (WIDTH+1)'(1);

    // One guard bit keeps MODULUS == 2**WIDTH from aliasing during +/-1.
    logic [WIDTH:0]   q_ext;
    logic [WIDTH-1:0] load_clamped;

    assign q_ext        = {1'b0, q_i};
    assign load_clamped = (load_val_i > MAX_Q) ? MAX_Q : load_val_i;

    always_comb begin
        q_o        = q_i;
        boundary_o = 1'b0;
        unique case (op_i)
            OP_LOAD: q_o = load_clamped;
            OP_INC: begin
                if (q_i == MAX_Q) begin
                    boundary_o = 1'b1;
`ifdef COUNTER_SAT_EN
                    q_o        = MAX_Q;
`else
                    q_o        = '0;
`endif
                end else begin
                    q_o = WIDTH'(q_ext + ONE_W);
                end
            end
            OP_DEC: begin
                if (q_i == '0) begin
                    boundary_o = 1'b1;
`ifdef COUNTER_SAT_EN
                    q_o        = '0;
`else
                    q_o        = MAX_Q;
`endif
                end else begin
                    q_o = WIDTH'(q_ext - ONE_W);
                end
            end
            default: q_o = q_i;
        endcase
    end

endmodule

// File: rtl/updown_counter_param.sv
// rtl/updown_counter_param.sv - modulo up/down counter with load and terminal count; COUNTER_SAT_EN adds ovf
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int              WIDTH   = 3,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input logic                   clk,
    input logic                   rst_n,
    updown_counter_param_if.slave bus
);

    op_e              op;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             tc_q;
    logic             tc_d;

    always_comb begin
        op = OP_HOLD;
        if (bus.load) begin
            op = OP_LOAD;
        end else if (bus.en) begin
            op = (bus.up == DIR_UP) ? OP_INC : OP_DEC;
        end
    end

    counter_step #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_step (
        .q_i        (q_q),
        .op_i       (op),
        .load_val_i (bus.load_val),
        .q_o        (q_d),
        .boundary_o (tc_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q  <= '0;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    assign bus.Q  = q_q;
    assign bus.tc = tc_q;

`ifdef COUNTER_SAT_EN
    logic ovf_q;

    // Sticky until reset or an explicit load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (op == OP_LOAD) begin
            ovf_q <= 1'b0;
        end else if (tc_d) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_updown_counter_param.sv
// tb/tb_updown_counter_param.sv - randomized and directed bench for MODULUS 8 and 6 counters
module tb_updown_counter_param;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    updown_counter_param_if #(.WIDTH(3)) bus8();
    updown_counter_param_if #(.WIDTH(3)) bus6();

    updown_counter_param #(.WIDTH(3), .MODULUS(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    updown_counter_param #(.WIDTH(3), .MODULUS(6)) dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus6.slave)
    );

    int checks = 0;
    int errors = 0;

    int mods[2]  = '{8, 6};
    int m_q[2];
    int m_tc[2];
    int m_ovf[2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_edge(input int i, input bit r, input bit e, input bit u, input bit l, input int lv);
        int m;
        m = mods[i];
        if (!r) begin
            m_q[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
        end else if (l) begin
            m_q[i]   = (lv > m - 1) ? m - 1 : lv;
            m_tc[i]  = 0;
            m_ovf[i] = 0;
        end else if (e) begin
            int nxt;
            nxt     = u ? m_q[i] + 1 : m_q[i] - 1;
            m_tc[i] = (nxt == m || nxt == -1) ? 1 : 0;
`ifdef COUNTER_SAT_EN
            if (m_tc[i] != 0) m_ovf[i] = 1;
            m_q[i] = (nxt == m) ? m - 1 : (nxt == -1) ? 0 : nxt;
`else
            m_q[i] = (nxt + m) % m;
`endif
        end else begin
            m_tc[i] = 0;
        end
    endtask

    task automatic cyc(input bit r, input bit e, input bit u, input bit l, input int lv);
        rst_n         = r;
        bus8.en       = e;  bus6.en       = e;
        bus8.up       = u;  bus6.up       = u;
        bus8.load     = l;  bus6.load     = l;
        bus8.load_val = 3'(lv);
        bus6.load_val = 3'(lv);
        @(posedge clk);
        model_edge(0, r, e, u, l, lv);
        model_edge(1, r, e, u, l, lv);
        #1;
        check("q_mod8",  64'(bus8.Q),  64'(m_q[0]));
        check("tc_mod8", 64'(bus8.tc), 64'(m_tc[0]));
        check("q_mod6",  64'(bus6.Q),  64'(m_q[1]));
        check("tc_mod6", 64'(bus6.tc), 64'(m_tc[1]));
`ifdef COUNTER_SAT_EN
        check("ovf_mod8", 64'(bus8.ovf), 64'(m_ovf[0]));
        check("ovf_mod6", 64'(bus6.ovf), 64'(m_ovf[1]));
`endif
    endtask

    initial begin
        int exp30[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
        int exp31[7] = '{5, 4, 3, 2, 1, 0, 5};
        int held;

        cyc(0, 1, 1, 1, 5);
        check("reset_q", 64'(bus8.Q), 64'd0);
        check("reset_tc", 64'(bus8.tc), 64'd0);

        for (int k = 0; k < 9; k++) begin
            cyc(1, 1, 1, 0, 0);
`ifndef COUNTER_SAT_EN
            check("up8_seq_q", 64'(bus8.Q), 64'(exp30[k]));
            check("up8_seq_tc", 64'(bus8.tc), 64'(exp30[k] == 0));
`endif
        end

        cyc(0, 0, 0, 0, 0);
        for (int k = 0; k < 7; k++) begin
            cyc(1, 1, 0, 0, 0);
`ifndef COUNTER_SAT_EN
            check("down6_seq_q", 64'(bus6.Q), 64'(exp31[k]));
            check("down6_seq_tc", 64'(bus6.tc), 64'(exp31[k] == 5));
`endif
        end

        cyc(1, 0, 0, 1, 7);
        check("load_clamp6", 64'(bus6.Q), 64'd5);
        cyc(1, 1, 1, 1, 2);
        check("load_wins_q", 64'(bus6.Q), 64'd2);
        check("load_wins_tc", 64'(bus6.tc), 64'd0);

        cyc(1, 1, 1, 1, 3);
        cyc(1, 1, 1, 0, 0);
        check("count_to_4", 64'(bus8.Q), 64'd4);
        cyc(0, 1, 1, 0, 0);
        check("mid_reset_q", 64'(bus8.Q), 64'd0);
        check("mid_reset_tc", 64'(bus8.tc), 64'd0);
        cyc(1, 1, 1, 0, 0);
        check("after_reset_q", 64'(bus8.Q), 64'd1);

        held = m_q[0];
        for (int k = 0; k < 5; k++) begin
            cyc(1, 0, k[0], 0, 0);
            check("hold_q", 64'(bus8.Q), 64'(held));
            check("hold_tc", 64'(bus8.tc), 64'd0);
        end

`ifdef COUNTER_SAT_EN
        cyc(1, 0, 0, 1, 6);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 1, 1, 0, 0);
            check("sat_q", 64'(bus8.Q), 64'd7);
        end
        check("sat_ovf", 64'(bus8.ovf), 64'd1);
        cyc(1, 0, 0, 1, 0);
        check("sat_ovf_clear", 64'(bus8.ovf), 64'd0);
        check("sat_load0_q", 64'(bus8.Q), 64'd0);
`endif

        for (int k = 0; k < 500; k++) begin
            cyc($urandom_range(0, 31) != 0, $urandom_range(0, 3) != 0,
                1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
                int'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/updown_counter_param.md
UPDOWN_COUNTER_PARAM -- requirements
Module: updown_counter_param

Interface
REQ-001 Parameter WIDTH, default 3: counter width in bits, legal range 1..32.
REQ-002 Parameter MODULUS, default 2**WIDTH: count sequence length; legal range 2..2**WIDTH; count range 0..MODULUS-1.
REQ-003 Port clk input 1: sole clock; all state updates on posedge clk.
REQ-004 Port rst_n input 1: reset, synchronous, active-low.
REQ-005 Port en input 1: count enable.
REQ-006 Port up input 1: direction; 1 = increment, 0 = decrement.
REQ-007 Port load input 1: parallel load strobe.
REQ-008 Port load_val input WIDTH: value for parallel load.
REQ-009 Port Q output WIDTH: registered count value.
REQ-010 Port tc output 1: registered terminal-count pulse.
REQ-011 Port ovf output 1: sticky overflow flag; present only when COUNTER_SAT_EN is defined.

Function
REQ-012 Per-edge priority: rst_n low > load high > en high > hold.
REQ-013 Load: Q <= load_val when load_val <= MODULUS-1, else Q <= MODULUS-1 (clamped); tc <= 0; direction and en ignored.
REQ-014 Hold (en low, no load): Q unchanged; tc <= 0.
REQ-015 Up count, Q < MODULUS-1: Q <= Q+1; tc <= 0.
REQ-016 Up count, Q == MODULUS-1: Q <= 0 (wrap); tc <= 1.
REQ-017 Down count, Q > 0: Q <= Q-1; tc <= 0.
REQ-018 Down count, Q == 0: Q <= MODULUS-1 (wrap); tc <= 1.
REQ-019 tc is high for exactly one cycle per boundary event and high on consecutive cycles only if consecutive boundary events occur.
REQ-020 Latency: Q and tc reflect the inputs sampled at the previous posedge; one-cycle latency, no combinational input-to-output path.
REQ-021 Direction change takes effect on the next enabled edge; no extra cycle, no glitch state.
REQ-022 Internal arithmetic is WIDTH+1 bits wide, so MODULUS == 2**WIDTH wraps correctly without truncation error.

Reset
REQ-023 On a posedge with rst_n low: Q <= 0, tc <= 0, ovf <= 0 (when present); load and en are ignored.
REQ-024 Reset asserted mid-count aborts the count; the first enabled edge after release counts from 0.
REQ-025 Before the first reset edge, outputs are undefined; benches apply reset first.

Configuration
REQ-026 Macro COUNTER_SAT_EN defined: saturating mode. At an up boundary Q holds MODULUS-1; at a down boundary Q holds 0. tc pulses as in REQ-016/018 and ovf <= 1 (sticky). ovf is cleared only by reset or load.
REQ-027 Macro COUNTER_SAT_EN undefined: wrap mode per REQ-016/018; ovf port and its logic are absent.

Structure
REQ-028 Shared package counter_pkg holds the direction constants (DIR_UP=1, DIR_DOWN=0) and an op-code typedef {OP_HOLD, OP_LOAD, OP_INC, OP_DEC}.
REQ-029 Sub-module counter_step (combinational) computes next Q, the boundary flag and the clamped load value from Q, the op-code and MODULUS; updown_counter_param contains only the op decode and the registers.

Verification
REQ-030 WIDTH=3, MODULUS=8: reset, then en=1, up=1 for 9 edges -> Q = 1..7,0,1; tc high only in the cycle Q=0.
REQ-031 WIDTH=3, MODULUS=6: reset, then en=1, up=0 -> Q = 5,4,3,2,1,0,5; tc high in both cycles where Q=5.
REQ-032 load=1, load_val=7, MODULUS=6 -> Q=5 (clamped); load=1 and en=1 on the same edge -> load wins; tc=0.
REQ-033 Count to Q=4, then drive rst_n=0 for 1 edge with en=1 -> Q=0, tc=0; next enabled up edge -> Q=1.
REQ-034 With COUNTER_SAT_EN, MODULUS=8: load 6, count up 3 edges -> Q = 7,7,7; tc pulses in each cycle Q holds at 7; ovf=1 and stays 1 until load 0 -> ovf=0, Q=0.
REQ-035 en=0 with up toggling for 5 edges -> Q unchanged, tc=0 throughout.
